immediate_extension_unit: RTL and testbench

//  Parametrised, pipelined immediate-extension stage for the decode path.

---
 rtl/immediate_extension_unit.sv | 91 +++++++++
 tb/tb_immediate_extension_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_extension_unit.sv
// Widens an immediate by sign, zero, upper-place or sign+shift mode and forwards it with its tag.
// Latency 1 cycle; a one-entry skid register sustains full throughput.
// in_ready is registered (~skid valid) with no combinational path from out_ready.
module immediate_extension_unit #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32,
   parameter int SHIFT     = 2,
   parameter int TAG_WIDTH = 5
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic [1:0]           in_mode,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic [TAG_WIDTH-1:0] out_tag
);
   localparam int E = OUT_WIDTH - IN_WIDTH;

   typedef struct packed {
      logic [OUT_WIDTH-1:0] dat;
      logic [TAG_WIDTH-1:0] tag;
   } slot_t;

   logic [OUT_WIDTH-1:0] zext;
   logic [OUT_WIDTH-1:0] sext;
   logic [OUT_WIDTH-1:0] ext;
   slot_t                new_slot;
   slot_t                or_q;
   slot_t                sr_q;
   logic                 ov_q;
   logic                 sv_q;
   logic                 acc;
   logic                 drn;

   // Loop-based fill keeps E = 0 legal without a zero-width replication.
   always_comb begin
      zext = '0;
      zext[IN_WIDTH-1:0] = in_data;
      sext = zext;
      for (int i = IN_WIDTH; i < OUT_WIDTH; i++) begin
         sext[i] = in_data[IN_WIDTH-1];
      end
      ext = sext;
      case (in_mode)
         2'b00:   ext = sext;
         2'b01:   ext = zext;
         2'b10:   ext = zext << E;
         default: ext = sext << SHIFT;
      endcase
   end

   assign new_slot = '{dat: ext, tag: in_tag};
   assign acc      = in_valid & ~sv_q;
   assign drn      = ov_q & out_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         or_q <= '0;
         sr_q <= '0;
         ov_q <= 1'b0;
         sv_q <= 1'b0;
      end else if (sv_q) begin
         // Skid entry is always younger than the output entry, so it refills OR.
         if (drn) begin
            or_q <= sr_q;
            sv_q <= 1'b0;
         end
      end else if (acc) begin
         if (!ov_q || out_ready) begin
            or_q <= new_slot;
            ov_q <= 1'b1;
         end else begin
            sr_q <= new_slot;
            sv_q <= 1'b1;
         end
      end else if (drn) begin
         ov_q <= 1'b0;
      end
   end

   assign in_ready  = ~sv_q;
   assign out_valid = ov_q;
   assign out_data  = or_q.dat;
   assign out_tag   = or_q.tag;

endmodule

// File: tb/tb_immediate_extension_unit.sv
// Bench for immediate_extension_unit: two parameterisations checked against an arithmetic model and scoreboard.
module tb_immediate_extension_unit;
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [15:0] a_in_data;
   logic [1:0]  a_in_mode;
   logic [4:0]  a_in_tag, a_out_tag;
   logic [31:0] a_out_data;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0]  b_in_data;
   logic [1:0]  b_in_mode;
   logic [4:0]  b_in_tag, b_out_tag;
   logic [15:0] b_out_data;

   immediate_extension_unit #(.IN_WIDTH(16), .OUT_WIDTH(32), .SHIFT(2), .TAG_WIDTH(5)) dut_a (
      .clock(clock), .reset_n(reset_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_mode(a_in_mode), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_tag(a_out_tag));

   immediate_extension_unit #(.IN_WIDTH(8), .OUT_WIDTH(16), .SHIFT(1), .TAG_WIDTH(5)) dut_b (
      .clock(clock), .reset_n(reset_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_mode(b_in_mode), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_tag(b_out_tag));

   typedef struct {
      logic [31:0] dat;
      logic [4:0]  tag;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   int          total = 0;
   int          bad = 0;
   int          pops_a = 0, pops_b = 0, acc_a = 0, acc_b = 0;
   logic        stall_a = 1'b0, stall_b = 1'b0;
   logic [31:0] hold_dat_a, hold_dat_b;
   logic [4:0]  hold_tag_a, hold_tag_b;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Value semantics of each mode, computed as integers and reduced modulo 2^ow.
   function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m,
                                           input int iw, input int ow, input int sh);
      longint u, s, r, mask;
      u = longint'(d) & ((longint'(1) << iw) - 1);
      s = (u >= (longint'(1) << (iw - 1))) ? u - (longint'(1) << iw) : u;
      case (m)
         2'b00:   r = s;
         2'b01:   r = u;
         2'b10:   r = u * (longint'(1) << (ow - iw));
         default: r = s * (longint'(1) << sh);
      endcase
      mask = (longint'(1) << ow) - 1;
      return 32'(r & mask);
   endfunction

   task automatic step(input logic aiv, input logic [15:0] ad, input logic [1:0] am,
                       input logic [4:0] at, input logic aor,
                       input logic biv, input logic [7:0] bd, input logic [1:0] bm,
                       input logic [4:0] bt, input logic bor);
      exp_t e;
      @(negedge clock);
      a_in_valid = aiv; a_in_data = ad; a_in_mode = am; a_in_tag = at; a_out_ready = aor;
      b_in_valid = biv; b_in_data = bd; b_in_mode = bm; b_in_tag = bt; b_out_ready = bor;
      if (stall_a) begin
         chk("a_stable_dat", a_out_data, hold_dat_a);
         chk("a_stable_tag", a_out_tag, hold_tag_a);
      end
      if (stall_b) begin
         chk("b_stable_dat", b_out_data, hold_dat_b);
         chk("b_stable_tag", b_out_tag, hold_tag_b);
      end
      // Retire the oldest result before recording a new accept.
      if (a_out_valid && a_out_ready) begin
         pops_a++;
         if (qa.size() == 0) chk("a_unexpected_out", 64'(qa.size()), 1);
         else begin
            e = qa.pop_front();
            chk("a_dat", a_out_data, e.dat);
            chk("a_tag", a_out_tag, e.tag);
         end
      end
      if (b_out_valid && b_out_ready) begin
         pops_b++;
         if (qb.size() == 0) chk("b_unexpected_out", 64'(qb.size()), 1);
         else begin
            e = qb.pop_front();
            chk("b_dat", b_out_data, e.dat);
            chk("b_tag", b_out_tag, e.tag);
         end
      end
      if (a_in_valid && a_in_ready) begin
         qa.push_back('{ref_ext(ad, am, 16, 32, 2), at});
         acc_a++;
      end
      if (b_in_valid && b_in_ready) begin
         qb.push_back('{ref_ext({8'h00, bd}, bm, 8, 16, 1), bt});
         acc_b++;
      end
      stall_a = a_out_valid && !a_out_ready;
      stall_b = b_out_valid && !b_out_ready;
      hold_dat_a = a_out_data; hold_tag_a = a_out_tag;
      hold_dat_b = 32'(b_out_data); hold_tag_b = b_out_tag;
   endtask

   task automatic stepa(input logic iv, input logic [15:0] d, input logic [1:0] m,
                        input logic [4:0] t, input logic ordy);
      step(iv, d, m, t, ordy, 1'b0, 8'h00, 2'b00, 5'd0, 1'b1);
   endtask

   task automatic stepb(input logic iv, input logic [7:0] d, input logic [1:0] m,
                        input logic [4:0] t, input logic ordy);
      step(1'b0, 16'h0000, 2'b00, 5'd0, 1'b1, iv, d, m, t, ordy);
   endtask

   task automatic check_reset_state(input string pfx);
      chk({pfx, "_a_out_valid"}, a_out_valid, 0);
      chk({pfx, "_a_in_ready"},  a_in_ready, 1);
      chk({pfx, "_a_out_data"},  a_out_data, 0);
      chk({pfx, "_a_out_tag"},   a_out_tag, 0);
      chk({pfx, "_b_out_valid"}, b_out_valid, 0);
      chk({pfx, "_b_in_ready"},  b_in_ready, 1);
      chk({pfx, "_b_out_data"},  b_out_data, 0);
      chk({pfx, "_b_out_tag"},   b_out_tag, 0);
   endtask

   logic [15:0] dir_d [6] = '{16'h8001, 16'h8001, 16'h7FFF, 16'h1234, 16'hFFFE, 16'h0001};
   logic [1:0]  dir_m [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11};
   logic [31:0] dir_e [6] = '{32'hFFFF8001, 32'h00008001, 32'h00007FFF,
                              32'h12340000, 32'hFFFFFFF8, 32'h00000004};
   logic [7:0]  dirb_d [3] = '{8'h80, 8'h12, 8'hFF};
   logic [1:0]  dirb_m [3] = '{2'b00, 2'b10, 2'b11};
   logic [15:0] dirb_e [3] = '{16'hFF80, 16'h1200, 16'hFFFE};

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, pbase, cyc;
      reset_n = 1'b0;
      a_in_valid = 0; a_in_data = 0; a_in_mode = 0; a_in_tag = 0; a_out_ready = 0;
      b_in_valid = 0; b_in_data = 0; b_in_mode = 0; b_in_tag = 0; b_out_ready = 0;
      repeat (2) @(negedge clock);
      check_reset_state("rst");
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         stepa(1'b1, dir_d[i], dir_m[i], 5'(i), 1'b1);
         stepa(1'b0, 16'h0000, 2'b00, 5'd0, 1'b1);
         chk("a_dir_const", a_out_data, dir_e[i]);
      end
      for (int i = 0; i < 3; i++) begin
         stepb(1'b1, dirb_d[i], dirb_m[i], 5'(i + 8), 1'b1);
         stepb(1'b0, 8'h00, 2'b00, 5'd0, 1'b1);
         chk("b_dir_const", b_out_data, dirb_e[i]);
      end

      // Streaming: one result per cycle, one-cycle latency.
      base = pops_a;
      for (int i = 0; i < 100; i++) begin
         stepa(1'b1, 16'($urandom), 2'($urandom), 5'($urandom), 1'b1);
         if (i > 0) chk("stream_rate", 64'(pops_a - base), 64'(i));
         chk("stream_in_ready", a_in_ready, 1);
      end
      stepa(1'b0, 16'h0000, 2'b00, 5'd0, 1'b1);
      chk("stream_drained", 64'(qa.size()), 0);

      // Back-pressure with two entries held.
      stepa(1'b1, 16'h0011, 2'b00, 5'd1, 1'b0);
      stepa(1'b1, 16'h0022, 2'b01, 5'd2, 1'b0);
      stepa(1'b0, 16'h0000, 2'b00, 5'd0, 1'b0);
      chk("bp_in_ready_low", a_in_ready, 0);
      chk("bp_out_tag_held", a_out_tag, 1);
      stepa(1'b0, 16'h0000, 2'b00, 5'd0, 1'b0);
      chk("bp_out_tag_still", a_out_tag, 1);
      stepa(1'b0, 16'h0000, 2'b00, 5'd0, 1'b1);
      pbase = pops_a;
      stepa(1'b0, 16'h0000, 2'b00, 5'd0, 1'b1);
      chk("bp_in_ready_back", a_in_ready, 1);
      chk("bp_second_tag", a_out_tag, 2);
      chk("bp_consecutive", 64'(pops_a - pbase), 1);
      stepa(1'b0, 16'h0000, 2'b00, 5'd0, 1'b1);
      chk("bp_drained", 64'(qa.size()), 0);

      // Random valid/ready toggling on both instances.
      base = acc_a; pbase = pops_a; cyc = 0;
      while ((acc_a - base) < 10000 && cyc < 40000) begin
         stepa(($urandom % 10) < 7, 16'($urandom), 2'($urandom), 5'($urandom), ($urandom % 10) < 6);
         cyc++;
      end
      chk("rand_a_accepts", 64'(acc_a - base), 10000);
      for (int i = 0; i < 4; i++) stepa(1'b0, 16'h0000, 2'b00, 5'd0, 1'b1);
      chk("rand_a_drained", 64'(qa.size()), 0);
      chk("rand_a_pops", 64'(pops_a - pbase), 64'(acc_a - base));

      base = acc_b; pbase = pops_b; cyc = 0;
      while ((acc_b - base) < 400 && cyc < 4000) begin
         stepb(($urandom % 10) < 6, 8'($urandom), 2'($urandom), 5'($urandom), ($urandom % 10) < 5);
         cyc++;
      end
      chk("rand_b_accepts", 64'(acc_b - base), 400);
      for (int i = 0; i < 4; i++) stepb(1'b0, 8'h00, 2'b00, 5'd0, 1'b1);
      chk("rand_b_drained", 64'(qb.size()), 0);
      chk("rand_b_pops", 64'(pops_b - pbase), 64'(acc_b - base));

      // Asynchronous reset with both OR and SR occupied.
      step(1'b1, 16'h0101, 2'b00, 5'd3, 1'b0, 1'b1, 8'h81, 2'b00, 5'd4, 1'b0);
      step(1'b1, 16'h0202, 2'b01, 5'd5, 1'b0, 1'b1, 8'h82, 2'b01, 5'd6, 1'b0);
      step(1'b0, 16'h0000, 2'b00, 5'd0, 1'b0, 1'b0, 8'h00, 2'b00, 5'd0, 1'b0);
      chk("full_a_in_ready", a_in_ready, 0);
      chk("full_b_in_ready", b_in_ready, 0);
      #2 reset_n = 1'b0;
      #1 check_reset_state("async_rst");
      qa.delete(); qb.delete();
      stall_a = 1'b0; stall_b = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      pbase = pops_a; base = pops_b;
      step(1'b1, 16'hC003, 2'b11, 5'd9, 1'b1, 1'b1, 8'hC3, 2'b11, 5'd10, 1'b1);
      for (int i = 0; i < 5; i++)
         step(1'b0, 16'h0000, 2'b00, 5'd0, 1'b1, 1'b0, 8'h00, 2'b00, 5'd0, 1'b1);
      chk("post_rst_a_single", 64'(pops_a - pbase), 1);
      chk("post_rst_b_single", 64'(pops_b - base), 1);
      chk("post_rst_a_empty", 64'(qa.size()), 0);
      chk("post_rst_b_empty", 64'(qb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
